uart_rx: RTL and testbench

UART receiver, the receive-side counterpart of the team's uart_tx. It takes the asynchronous serial line, synchronizes it, and detects the start bit. It samples each bit at its centre and delivers one parallel word per frame as a single-cycle valid pulse, with parity and framing error flags. Parameters and frame format match uart_tx, so a tx/rx pair with identical parameters loops back cleanly.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_if.sv | 26 ++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx.sv | 144 ++++++++++++++
 tb/tb_uart_rx.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding
// and the bit-period computation common to tx and rx.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } state_e;

   // Clocks per bit for a clock in MHz and a baud rate in bit/s.
   function automatic int unsigned cycles(
      input int unsigned clk_fre,
      input int unsigned baud
   );
      return (clk_fre * 1000000) / baud;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-word bundle: parallel data, one-cycle valid
// pulse and the per-frame error flags.
interface uart_rx_if #(
   parameter int DATA_WIDTH = 8
);

   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_data_valid;
   logic                  o_parity_err;
   logic                  o_frame_err;

   modport master (
      output o_data,
      output o_data_valid,
      output o_parity_err,
      output o_frame_err
   );

   modport slave (
      input o_data,
      input o_data_valid,
      input o_parity_err,
      input o_frame_err
   );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a
// history flop giving a one-cycle falling-edge flag.
module uart_rx_sync (
   input  logic i_clk_sys,
   input  logic i_rst_n,
   input  logic rx_i,
   output logic rx_o,
   output logic fall_o
);

   logic s1_q;
   logic s2_q;
   logic hist_q;

   // Resync the line and keep one cycle of history; idle is high.
   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_q   <= 1'b1;
         s2_q   <= 1'b1;
         hist_q <= 1'b1;
      end else begin
         s1_q   <= rx_i;
         s2_q   <= s1_q;
         hist_q <= s2_q;
      end
   end

   assign rx_o   = s2_q;
   assign fall_o = hist_q & ~s2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit detect, mid-bit sampling,
// parity/framing checks, one-cycle valid per frame.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FRE     = 50,
   parameter int DATA_WIDTH  = 8,
   parameter int PARITY_ON   = 0,
   parameter int PARITY_TYPE = 0,
   parameter int BAUD_RATE   = 9600
) (
   input  logic      i_clk_sys,
   input  logic      i_rst_n,
   input  logic      i_uart_rx,
   uart_rx_if.master bus
);

   localparam int CYCLE = int'(cycles(CLK_FRE, BAUD_RATE));
   localparam logic [15:0] MID  = 16'(CYCLE / 2 - 1);
   localparam logic [15:0] WRAP = 16'(CYCLE - 1);
   localparam logic [3:0]  NBIT = 4'(DATA_WIDTH);

   logic rx_s;
   logic fall;

   uart_rx_sync u_sync (
      .i_clk_sys (i_clk_sys),
      .i_rst_n   (i_rst_n),
      .rx_i      (i_uart_rx),
      .rx_o      (rx_s),
      .fall_o    (fall)
   );

   state_e                state_q, state_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [3:0]            bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shr_q, shr_d;
   logic                  par_q, par_d;
   logic                  perr_q, perr_d;
   logic                  done_q, done_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  operr_q, operr_d;
   logic                  oferr_q, oferr_d;
   logic                  valid_q;

   logic strobe;
   logic wrap;

   assign strobe = (cnt_q == MID);
   assign wrap   = (cnt_q == WRAP);

   // Frame sequencing, sampling and output capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = (state_q == IDLE) ? 16'd0 :
                (wrap ? 16'd0 : cnt_q + 16'd1);
      bit_d   = bit_q;
      shr_d   = shr_q;
      par_d   = par_q;
      perr_d  = perr_q;
      done_d  = 1'b0;
      data_d  = data_q;
      operr_d = operr_q;
      oferr_d = oferr_q;
      case (state_q)
         IDLE: begin
            if (fall) begin
               state_d = START;
               cnt_d   = 16'd0;
               bit_d   = 4'd0;
               par_d   = 1'b0;
               perr_d  = 1'b0;
            end
         end
         START: begin
            if (strobe && rx_s) state_d = IDLE;
            else if (wrap)      state_d = DATA;
         end
         DATA: begin
            if (strobe) begin
               shr_d = {rx_s, shr_q[DATA_WIDTH-1:1]};
               par_d = par_q ^ rx_s;
               bit_d = bit_q + 4'd1;
            end
            if (wrap && bit_q == NBIT)
               state_d = (PARITY_ON != 0) ? PARITY : STOP;
         end
         PARITY: begin
            if (strobe)
               perr_d = (PARITY_TYPE != 0) ? ~(par_q ^ rx_s)
                                           : (par_q ^ rx_s);
            if (wrap) state_d = STOP;
         end
         STOP: begin
            if (strobe) begin
               data_d  = shr_q;
               operr_d = perr_q;
               oferr_d = ~rx_s;
               done_d  = 1'b1;
               state_d = rx_s ? IDLE : WAIT_HIGH;
            end
         end
         WAIT_HIGH: begin
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shr_q   <= '0;
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
         done_q  <= 1'b0;
         data_q  <= '0;
         operr_q <= 1'b0;
         oferr_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shr_q   <= shr_d;
         par_q   <= par_d;
         perr_q  <= perr_d;
         done_q  <= done_d;
         data_q  <= data_d;
         operr_q <= operr_d;
         oferr_q <= oferr_d;
         valid_q <= done_q;
      end
   end

   assign bus.o_data       = data_q;
   assign bus.o_data_valid = valid_q;
   assign bus.o_parity_err = operr_q;
   assign bus.o_frame_err  = oferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three receivers (no parity, even,
// odd) each on its own bench-driven serial line.
module tb_uart_rx;

   localparam int BIT = 50;

   typedef struct {
      int         dut;
      logic [7:0] d;
      logic       pe;
      logic       fe;
      int         cyc;
   } rec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ln_np = 1'b1;
   logic ln_ev = 1'b1;
   logic ln_od = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   rec_t expq[$];
   rec_t rxq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_if #(.DATA_WIDTH(8)) if_np ();
   uart_rx_if #(.DATA_WIDTH(8)) if_ev ();
   uart_rx_if #(.DATA_WIDTH(8)) if_od ();

   uart_rx #(
      .CLK_FRE(50), .DATA_WIDTH(8), .PARITY_ON(0),
      .PARITY_TYPE(0), .BAUD_RATE(1000000)
   ) u_np (
      .i_clk_sys (clk),
      .i_rst_n   (rst_n),
      .i_uart_rx (ln_np),
      .bus       (if_np)
   );

   uart_rx #(
      .CLK_FRE(50), .DATA_WIDTH(8), .PARITY_ON(1),
      .PARITY_TYPE(0), .BAUD_RATE(1000000)
   ) u_ev (
      .i_clk_sys (clk),
      .i_rst_n   (rst_n),
      .i_uart_rx (ln_ev),
      .bus       (if_ev)
   );

   uart_rx #(
      .CLK_FRE(50), .DATA_WIDTH(8), .PARITY_ON(1),
      .PARITY_TYPE(1), .BAUD_RATE(1000000)
   ) u_od (
      .i_clk_sys (clk),
      .i_rst_n   (rst_n),
      .i_uart_rx (ln_od),
      .bus       (if_od)
   );

   function automatic rec_t mk(input int dut, input logic [7:0] d,
                               input logic pe, input logic fe,
                               input int c);
      rec_t r;
      r.dut = dut; r.d = d; r.pe = pe; r.fe = fe; r.cyc = c;
      return r;
   endfunction

   // Record every valid pulse from every receiver.
   always @(negedge clk) begin
      if (if_np.o_data_valid)
         rxq.push_back(mk(0, if_np.o_data, if_np.o_parity_err,
                          if_np.o_frame_err, cyc));
      if (if_ev.o_data_valid)
         rxq.push_back(mk(1, if_ev.o_data, if_ev.o_parity_err,
                          if_ev.o_frame_err, cyc));
      if (if_od.o_data_valid)
         rxq.push_back(mk(2, if_od.o_data, if_od.o_parity_err,
                          if_od.o_frame_err, cyc));
   end

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_line(input int dut, input logic v);
      case (dut)
         0:       ln_np = v;
         1:       ln_ev = v;
         default: ln_od = v;
      endcase
   endtask

   // Drive one frame; line is left at the stop-bit level.
   task automatic send(input int dut, input logic [7:0] d,
                       input bit par, input logic pb,
                       input logic stop, output int stop_cyc);
      set_line(dut, 1'b0);
      hold(BIT);
      for (int i = 0; i < 8; i++) begin
         set_line(dut, d[i]);
         hold(BIT);
      end
      if (par) begin
         set_line(dut, pb);
         hold(BIT);
      end
      set_line(dut, stop);
      stop_cyc = cyc;
      hold(BIT);
   endtask

   task automatic test_reset();
      hold(3);
      checks++;
      if ({if_np.o_data, if_np.o_data_valid, if_np.o_parity_err,
           if_np.o_frame_err} !== 11'd0) begin
         errors++;
         $display("FAIL reset_np got %h want 0", {if_np.o_data,
                  if_np.o_data_valid, if_np.o_parity_err,
                  if_np.o_frame_err});
      end
      checks++;
      if ({if_ev.o_data, if_ev.o_data_valid, if_ev.o_parity_err,
           if_ev.o_frame_err} !== 11'd0) begin
         errors++;
         $display("FAIL reset_ev got %h want 0", {if_ev.o_data,
                  if_ev.o_data_valid, if_ev.o_parity_err,
                  if_ev.o_frame_err});
      end
      checks++;
      if ({if_od.o_data, if_od.o_data_valid, if_od.o_parity_err,
           if_od.o_frame_err} !== 11'd0) begin
         errors++;
         $display("FAIL reset_od got %h want 0", {if_od.o_data,
                  if_od.o_data_valid, if_od.o_parity_err,
                  if_od.o_frame_err});
      end
      rst_n = 1'b1;
      hold(2 * BIT);
      checks++;
      if (rxq.size() != 0 || if_np.o_data_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_pulse got %0d want 0", rxq.size());
      end
      rxq.delete();
   endtask

   task automatic test_single();
      int   sc;
      rec_t r;
      expq.push_back(mk(0, 8'hA5, 1'b0, 1'b0, 0));
      send(0, 8'hA5, 1'b0, 1'b0, 1'b1, sc);
      hold(BIT);
      checks++;
      if (rxq.size() != 1) begin
         errors++;
         $display("FAIL single_count got %0d want 1", rxq.size());
      end
      if (rxq.size() > 0) begin
         r = rxq.pop_front();
         checks++;
         if (r.d !== expq[0].d || r.pe !== 1'b0 || r.fe !== 1'b0)
         begin
            errors++;
            $display("FAIL single_data got %h/%b/%b want %h/0/0",
                     r.d, r.pe, r.fe, expq[0].d);
         end
         checks++;
         if (r.cyc - sc < 26 || r.cyc - sc > 32) begin
            errors++;
            $display("FAIL single_latency got %0d want 26..32",
                     r.cyc - sc);
         end
      end
      expq.delete();
      rxq.delete();
   endtask

   task automatic test_back_to_back();
      int         sc;
      rec_t       e, r;
      logic [7:0] v[3];
      v[0] = 8'h00; v[1] = 8'hFF; v[2] = 8'h55;
      for (int i = 0; i < 3; i++) begin
         expq.push_back(mk(0, v[i], 1'b0, 1'b0, 0));
         send(0, v[i], 1'b0, 1'b0, 1'b1, sc);
      end
      hold(BIT);
      checks++;
      if (rxq.size() != 3) begin
         errors++;
         $display("FAIL b2b_count got %0d want 3", rxq.size());
      end
      while (expq.size() > 0 && rxq.size() > 0) begin
         e = expq.pop_front();
         r = rxq.pop_front();
         checks++;
         if (r.dut != e.dut || r.d !== e.d || r.pe !== e.pe ||
             r.fe !== e.fe) begin
            errors++;
            $display("FAIL b2b_data got %0d:%h/%b/%b want %0d:%h/%b/%b",
                     r.dut, r.d, r.pe, r.fe, e.dut, e.d, e.pe, e.fe);
         end
      end
      expq.delete();
      rxq.delete();
   endtask

   task automatic test_parity();
      int   sc;
      rec_t e, r;
      expq.push_back(mk(1, 8'h07, 1'b0, 1'b0, 0));
      send(1, 8'h07, 1'b1, 1'b1, 1'b1, sc);
      hold(BIT);
      expq.push_back(mk(1, 8'h07, 1'b1, 1'b0, 0));
      send(1, 8'h07, 1'b1, 1'b0, 1'b1, sc);
      hold(BIT);
      expq.push_back(mk(2, 8'h07, 1'b0, 1'b0, 0));
      send(2, 8'h07, 1'b1, 1'b0, 1'b1, sc);
      hold(BIT);
      expq.push_back(mk(2, 8'h07, 1'b1, 1'b0, 0));
      send(2, 8'h07, 1'b1, 1'b1, 1'b1, sc);
      hold(BIT);
      checks++;
      if (rxq.size() != 4) begin
         errors++;
         $display("FAIL parity_count got %0d want 4", rxq.size());
      end
      while (expq.size() > 0 && rxq.size() > 0) begin
         e = expq.pop_front();
         r = rxq.pop_front();
         checks++;
         if (r.dut != e.dut || r.d !== e.d || r.pe !== e.pe ||
             r.fe !== e.fe) begin
            errors++;
            $display("FAIL parity got %0d:%h/%b/%b want %0d:%h/%b/%b",
                     r.dut, r.d, r.pe, r.fe, e.dut, e.d, e.pe, e.fe);
         end
      end
      expq.delete();
      rxq.delete();
   endtask

   task automatic test_glitch();
      int   sc;
      rec_t e, r;
      set_line(0, 1'b0);
      hold(10);
      set_line(0, 1'b1);
      hold(2 * BIT);
      checks++;
      if (rxq.size() != 0) begin
         errors++;
         $display("FAIL glitch_pulse got %0d want 0", rxq.size());
      end
      expq.push_back(mk(0, 8'h3C, 1'b0, 1'b0, 0));
      send(0, 8'h3C, 1'b0, 1'b0, 1'b1, sc);
      hold(BIT);
      checks++;
      if (rxq.size() != 1) begin
         errors++;
         $display("FAIL glitch_count got %0d want 1", rxq.size());
      end
      while (expq.size() > 0 && rxq.size() > 0) begin
         e = expq.pop_front();
         r = rxq.pop_front();
         checks++;
         if (r.dut != e.dut || r.d !== e.d || r.pe !== e.pe ||
             r.fe !== e.fe) begin
            errors++;
            $display("FAIL glitch_data got %h/%b/%b want %h/%b/%b",
                     r.d, r.pe, r.fe, e.d, e.pe, e.fe);
         end
      end
      expq.delete();
      rxq.delete();
   endtask

   task automatic test_frame_err();
      int   sc;
      rec_t e, r;
      expq.push_back(mk(0, 8'h81, 1'b0, 1'b1, 0));
      send(0, 8'h81, 1'b0, 1'b0, 1'b0, sc);
      hold(30 * BIT - BIT);
      checks++;
      if (rxq.size() != 1) begin
         errors++;
         $display("FAIL break_count got %0d want 1", rxq.size());
      end
      set_line(0, 1'b1);
      hold(2 * BIT);
      expq.push_back(mk(0, 8'h12, 1'b0, 1'b0, 0));
      send(0, 8'h12, 1'b0, 1'b0, 1'b1, sc);
      hold(BIT);
      checks++;
      if (rxq.size() != 2) begin
         errors++;
         $display("FAIL ferr_count got %0d want 2", rxq.size());
      end
      while (expq.size() > 0 && rxq.size() > 0) begin
         e = expq.pop_front();
         r = rxq.pop_front();
         checks++;
         if (r.dut != e.dut || r.d !== e.d || r.pe !== e.pe ||
             r.fe !== e.fe) begin
            errors++;
            $display("FAIL ferr_data got %h/%b/%b want %h/%b/%b",
                     r.d, r.pe, r.fe, e.d, e.pe, e.fe);
         end
      end
      expq.delete();
      rxq.delete();
   endtask

   task automatic test_mid_reset();
      int         sc;
      rec_t       e, r;
      logic [7:0] c3;
      c3 = 8'hC3;
      set_line(0, 1'b0);
      hold(BIT);
      for (int i = 0; i < 3; i++) begin
         set_line(0, c3[i]);
         hold(BIT);
      end
      rst_n = 1'b0;
      set_line(0, 1'b1);
      hold(2);
      checks++;
      if ({if_np.o_data, if_np.o_data_valid, if_np.o_parity_err,
           if_np.o_frame_err} !== 11'd0) begin
         errors++;
         $display("FAIL midrst_outputs got %h want 0", {if_np.o_data,
                  if_np.o_data_valid, if_np.o_parity_err,
                  if_np.o_frame_err});
      end
      hold(5);
      rst_n = 1'b1;
      hold(BIT * 8);
      checks++;
      if (rxq.size() != 0) begin
         errors++;
         $display("FAIL midrst_pulse got %0d want 0", rxq.size());
      end
      expq.push_back(mk(0, 8'h5A, 1'b0, 1'b0, 0));
      send(0, 8'h5A, 1'b0, 1'b0, 1'b1, sc);
      hold(BIT);
      checks++;
      if (rxq.size() != 1) begin
         errors++;
         $display("FAIL midrst_count got %0d want 1", rxq.size());
      end
      while (expq.size() > 0 && rxq.size() > 0) begin
         e = expq.pop_front();
         r = rxq.pop_front();
         checks++;
         if (r.dut != e.dut || r.d !== e.d || r.pe !== e.pe ||
             r.fe !== e.fe) begin
            errors++;
            $display("FAIL midrst_data got %h/%b/%b want %h/%b/%b",
                     r.d, r.pe, r.fe, e.d, e.pe, e.fe);
         end
      end
      checks++;
      if (if_np.o_data !== 8'h5A) begin
         errors++;
         $display("FAIL midrst_hold got %h want 5a", if_np.o_data);
      end
      expq.delete();
      rxq.delete();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_parity();
      test_glitch();
      test_frame_err();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
